// File: rtl/spi_cmem_bridge_if.sv
// Pin and cmem-bus bundle for spi_cmem_bridge: the Pi-side SPI pins and the
// nibble-wide cmem strobe/address/data bus.
interface spi_cmem_bridge_if;
  logic       spi_sck;
  logic       spi_ss_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_read;
  logic       spi_write;
  logic [3:0] spi_address;
  logic [3:0] spi_out_cmem_in;
  logic [3:0] spi_in_cmem_out;

  // slave: the bridge itself (SPI slave, drives the cmem strobes)
  modport slave (
    input  spi_sck, spi_ss_n, spi_mosi, spi_in_cmem_out,
    output spi_miso, spi_read, spi_write, spi_address, spi_out_cmem_in
  );

  // master: the Pi pins plus the cmem read-data return
  modport master (
    output spi_sck, spi_ss_n, spi_mosi, spi_in_cmem_out,
    input  spi_miso, spi_read, spi_write, spi_address, spi_out_cmem_in
  );
endinterface

// File: rtl/spi_cmem_bridge.sv
// SPI mode-0 slave bridging Pi command bytes to cmem read/write strobes in clk200.
// Optional macro SPI_CMEM_BURST_EN enables op 0x3 auto-incrementing burst reads.
module spi_cmem_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk200,
  input  logic            reset,
  spi_cmem_bridge_if.slave bus
);

  localparam int P_SS   = 2;
  localparam int P_SCK  = 1;
  localparam int P_MOSI = 0;

  localparam logic [3:0] OP_WRITE = 4'h0;
  localparam logic [3:0] OP_READ  = 4'h1;
`ifdef SPI_CMEM_BURST_EN
  localparam logic [3:0] OP_BURST = 4'h3;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
`ifdef SPI_CMEM_BURST_EN
    BURST,
`endif
    IGNORE
  } state_e;

  // Synchronisers reset to 0 so SS_n already low at reset release gives no fall.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [1:0]                  hist_q;
  logic [2:0]                  pin_s;
  logic                        sck_rise, sck_fall, ss_rise, ss_fall;

  always_ff @(posedge clk200) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {bus.spi_ss_n, bus.spi_sck, bus.spi_mosi}};
      hist_q <= sync_q[SYNC_STAGES-1][2:1];
    end
  end

  assign pin_s    = sync_q[SYNC_STAGES-1];
  assign sck_rise =  pin_s[P_SCK] & ~hist_q[P_SCK-1];
  assign sck_fall = ~pin_s[P_SCK] &  hist_q[P_SCK-1];
  assign ss_rise  =  pin_s[P_SS]  & ~hist_q[P_SS-1];
  assign ss_fall  = ~pin_s[P_SS]  &  hist_q[P_SS-1];

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] ld_pipe_q, ld_pipe_d;
  logic [7:0] rx_byte;
  logic       byte_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    ld_pipe_d = {ld_pipe_q[0], rd_q};
    byte_done = 1'b0;
    rx_byte   = {rx_q, pin_s[P_MOSI]};

    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = CMD;
        cnt_d   = '0;
        rx_d    = '0;
        tx_d    = '0;
      end
    end else if (ss_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      tx_d    = '0;
    end else begin
      if (sck_rise) begin
        cnt_d     = cnt_q + 3'd1;
        rx_d      = rx_byte[6:0];
        byte_done = (cnt_q == 3'd7);
      end
      // The fall that opens a new byte must not shift: it exposes the fresh MSB.
      if (sck_fall && cnt_q != 3'd0)
        tx_d = {tx_q[6:0], 1'b0};

      if (byte_done) begin
        // Last bit was already sampled by the master; the next byte starts as 0x00.
        tx_d = '0;
        case (state_q)
          CMD: begin
            state_d = IGNORE;
            case (rx_byte[7:4])
              OP_WRITE: begin
                state_d = WDATA;
                addr_d  = rx_byte[3:0];
              end
              OP_READ: begin
                state_d = RDATA;
                addr_d  = rx_byte[3:0];
                rd_d    = 1'b1;
              end
`ifdef SPI_CMEM_BURST_EN
              OP_BURST: begin
                state_d = BURST;
                addr_d  = rx_byte[3:0];
                rd_d    = 1'b1;
              end
`endif
              default: ;
            endcase
          end
          WDATA: begin
            state_d = IGNORE;
            wdata_d = rx_byte[3:0];
            wr_d    = 1'b1;
          end
          RDATA: state_d = IGNORE;
`ifdef SPI_CMEM_BURST_EN
          BURST: begin
            addr_d = addr_q + 4'd1;
            rd_d   = 1'b1;
          end
`endif
          default: ;
        endcase
      end

      // cmem data is valid the cycle after spi_read; take it one cycle later.
      if (ld_pipe_q[1])
        tx_d = {4'b0000, bus.spi_in_cmem_out};
    end
  end

  always_ff @(posedge clk200) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ld_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ld_pipe_q <= ld_pipe_d;
    end
  end

  // tx_q is forced to zero whenever the frame is not active.
  assign bus.spi_miso        = tx_q[7];
  assign bus.spi_read        = rd_q;
  assign bus.spi_write       = wr_q;
  assign bus.spi_address     = addr_q;
  assign bus.spi_out_cmem_in = wdata_q;

endmodule

// File: tb/tb_spi_cmem_bridge.sv
// Directed bench for spi_cmem_bridge: SCK at four clk200 cycles per half-period,
// SYNC_STAGES=3, table-driven two-byte frames plus burst/abort/reset sequences.
module tb_spi_cmem_bridge;

  logic clk200 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk200 = ~clk200;

  spi_cmem_bridge_if bus ();

  spi_cmem_bridge #(.SYNC_STAGES(3)) dut (
    .clk200 (clk200),
    .reset  (reset),
    .bus    (bus)
  );

  // cmem stand-in: registered read data, either a constant or addr+1
  logic       cmem_inc = 1'b0;
  logic [3:0] cmem_val = 4'h0;
  logic [3:0] cmem_q   = 4'h0;
  always @(posedge clk200)
    if (bus.spi_read) cmem_q <= cmem_inc ? bus.spi_address + 4'd1 : cmem_val;
  assign bus.spi_in_cmem_out = cmem_q;

  // strobe monitor
  int         rd_total = 0, wr_total = 0, strobe_err = 0;
  logic [3:0] rd_log[$];
  logic [3:0] last_waddr = 4'h0, last_wdata = 4'h0;
  logic       prev_rd = 1'b0, prev_wr = 1'b0;
  always @(negedge clk200) begin
    if (bus.spi_read) begin
      rd_total++;
      rd_log.push_back(bus.spi_address);
    end
    if (bus.spi_write) begin
      wr_total++;
      last_waddr = bus.spi_address;
      last_wdata = bus.spi_out_cmem_in;
    end
    if ((bus.spi_read && bus.spi_write) || (bus.spi_read && (prev_rd || prev_wr)) ||
        (bus.spi_write && (prev_rd || prev_wr)))
      strobe_err++;
    prev_rd = bus.spi_read;
    prev_wr = bus.spi_write;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(posedge clk200);
    #3;
  endtask

  task automatic frame_begin();
    bus.spi_ss_n = 1'b0;
    half();
  endtask

  task automatic frame_end();
    half();
    bus.spi_ss_n = 1'b1;
    repeat (12) @(posedge clk200);
    #3;
  endtask

  // MISO sampled just before each rising SCK edge, as the Pi does
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = mo[i];
      half();
      mi = {mi[6:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      half();
      bus.spi_sck = 1'b0;
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [3:0] cval;
    int         n_rd;
    int         n_wr;
    logic [3:0] addr;
    logic [3:0] wdat;
    logic [7:0] miso1;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [7:0] m0, m1, m;
    logic [7:0] bexp[4];
    logic [3:0] baddr[5];
    int         rd0, wr0;

    vt[0] = '{"wr_B_5",   8'h0B, 8'h05, 4'h0, 0, 1, 4'hB, 4'h5, 8'h00};
    vt[1] = '{"rd_A_7",   8'h1A, 8'h00, 4'h7, 1, 0, 4'hA, 4'h0, 8'h07};
    vt[2] = '{"wr_F_hi",  8'h0F, 8'hA3, 4'h0, 0, 1, 4'hF, 4'h3, 8'h00};
    vt[3] = '{"rd_3_C",   8'h13, 8'h55, 4'hC, 1, 0, 4'h3, 4'h0, 8'h0C};
    vt[4] = '{"unk_F0",   8'hF0, 8'hFF, 4'h9, 0, 0, 4'h0, 4'h0, 8'h00};
    vt[5] = '{"wr_0_0",   8'h00, 8'h00, 4'h0, 0, 1, 4'h0, 4'h0, 8'h00};
    vt[6] = '{"unk_op2",  8'h25, 8'h01, 4'hE, 0, 0, 4'h0, 4'h0, 8'h00};

`ifdef SPI_CMEM_BURST_EN
    bexp  = '{8'h0F, 8'h00, 8'h01, 8'h02};
    baddr = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
`else
    bexp  = '{8'h00, 8'h00, 8'h00, 8'h00};
    baddr = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif

    bus.spi_sck  = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;

    repeat (5) @(posedge clk200);
    @(negedge clk200);
    check("rst_miso",  bus.spi_miso, 0);
    check("rst_read",  bus.spi_read, 0);
    check("rst_write", bus.spi_write, 0);
    check("rst_addr",  bus.spi_address, 0);
    check("rst_wdata", bus.spi_out_cmem_in, 0);
    @(posedge clk200);
    #3 reset = 1'b0;
    repeat (10) @(posedge clk200);
    #3;

    foreach (vt[k]) begin
      rd0 = rd_total;
      wr0 = wr_total;
      cmem_val = vt[k].cval;
      frame_begin();
      xfer(vt[k].cmd, 8, m0);
      xfer(vt[k].dat, 8, m1);
      frame_end();
      check({vt[k].name, "_miso0"}, m0, 0);
      check({vt[k].name, "_miso1"}, m1, vt[k].miso1);
      check({vt[k].name, "_nrd"}, rd_total - rd0, vt[k].n_rd);
      check({vt[k].name, "_nwr"}, wr_total - wr0, vt[k].n_wr);
      if (vt[k].n_rd > 0) check({vt[k].name, "_raddr"}, rd_log[rd0], vt[k].addr);
      if (vt[k].n_wr > 0) begin
        check({vt[k].name, "_waddr"}, last_waddr, vt[k].addr);
        check({vt[k].name, "_wdata"}, last_wdata, vt[k].wdat);
      end
    end

    // burst with address wrap, cmem returning addr+1
    cmem_inc = 1'b1;
    rd0 = rd_total;
    frame_begin();
    xfer(8'h3E, 8, m);
    check("burst_miso0", m, 0);
    for (int b = 0; b < 4; b++) begin
      xfer(8'h00, 8, m);
      check($sformatf("burst_miso%0d", b + 1), m, bexp[b]);
    end
    frame_end();
    cmem_inc = 1'b0;
`ifdef SPI_CMEM_BURST_EN
    check("burst_nrd", rd_total - rd0, 5);
    for (int k = 0; k < 5; k++)
      if (rd_total - rd0 == 5) check($sformatf("burst_addr%0d", k), rd_log[rd0 + k], baddr[k]);
`else
    check("burst_nrd", rd_total - rd0, 0);
`endif

    // abort mid data byte, then a clean write
    wr0 = wr_total;
    frame_begin();
    xfer(8'h04, 8, m);
    xfer(8'hFF, 5, m);
    frame_end();
    check("abort_nwr", wr_total - wr0, 0);
    frame_begin();
    xfer(8'h02, 8, m);
    xfer(8'h09, 8, m);
    frame_end();
    check("after_abort_nwr", wr_total - wr0, 1);
    check("after_abort_waddr", last_waddr, 4'h2);
    check("after_abort_wdata", last_wdata, 4'h9);

    // unknown op 0x7 with three data bytes
    rd0 = rd_total;
    wr0 = wr_total;
    cmem_val = 4'hF;
    frame_begin();
    xfer(8'h71, 8, m0);
    check("unk7_miso0", m0, 0);
    for (int b = 0; b < 3; b++) begin
      xfer(8'hFF, 8, m);
      check($sformatf("unk7_miso%0d", b + 1), m, 0);
    end
    frame_end();
    check("unk7_strobes", (rd_total - rd0) + (wr_total - wr0), 0);

    // back-to-back reads of addr 12
    rd0 = rd_total;
    cmem_val = 4'h5;
    frame_begin();
    xfer(8'h1C, 8, m0);
    xfer(8'h00, 8, m1);
    bus.spi_ss_n = 1'b1;
    half();
    check("rdC1_miso1", m1, 8'h05);
    cmem_val = 4'hA;
    frame_begin();
    xfer(8'h1C, 8, m0);
    xfer(8'h00, 8, m1);
    frame_end();
    check("rdC2_miso1", m1, 8'h0A);
    check("rdC_nrd", rd_total - rd0, 2);
    if (rd_total - rd0 == 2) check("rdC_addr", {rd_log[rd0], rd_log[rd0 + 1]}, 8'hCC);

    // reset mid-frame with SS_n held low: no frame until a fresh fall
    wr0 = wr_total;
    frame_begin();
    xfer(8'h05, 4, m);
    reset = 1'b1;
    repeat (3) @(posedge clk200);
    #3 reset = 1'b0;
    xfer(8'h03, 8, m0);
    xfer(8'h07, 8, m1);
    frame_end();
    check("midrst_nwr", wr_total - wr0, 0);
    check("midrst_miso", {m0, m1}, 0);
    check("midrst_addr", bus.spi_address, 0);
    frame_begin();
    xfer(8'h06, 8, m);
    xfer(8'h0D, 8, m);
    frame_end();
    check("postrst_waddr", last_waddr, 4'h6);
    check("postrst_wdata", last_wdata, 4'hD);

    check("strobe_shape", strobe_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk200);
    $display("FAIL watchdog: run exceeded 60000 cycles, expected completion");
    $fatal(1);
  end

endmodule
